// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among four requesters.
// Issues the start pulse, tracks tx_busy through the frame, acks the owner and flags dead starts.
module uart_tx_arbiter #(
  parameter int START_TIMEOUT = 16,
  parameter int GAP_CYCLES    = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  input  logic        tx_busy,
  output logic        enable_txd,
  output logic [7:0]  data,
  output logic [1:0]  grant_id,
  output logic        timeout_err,
  output logic        idle
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  localparam logic [7:0] START_LAST = 8'(START_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] timer;
  logic [1:0] last_grant;
  logic       busy_q;
  logic       grant;
  logic       ack_set;
  logic [1:0] winner;

  // First pending requester after the previous owner; the previous owner itself is tried last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign winner     = rr_pick(req, last_grant);
  assign enable_txd = (state == START);
  assign idle       = (state == IDLE);

  // busy_q keeps IDLE from granting on the very cycle a foreign frame ends.
  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    ack_set     = 1'b0;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        if ((|req) && !tx_busy && !busy_q) begin
          grant     = 1'b1;
          state_nxt = START;
        end
      end
      START: state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          ack_set   = 1'b1;
          state_nxt = WAIT_DONE;
        end else if (timer == START_LAST) begin
          timeout_err = 1'b1;
          state_nxt   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (timer == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The single timer restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      timer      <= 8'd0;
      last_grant <= 2'd3;
      grant_id   <= 2'd0;
      data       <= 8'h00;
      ack        <= 4'b0000;
      busy_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= tx_busy;
      ack    <= ack_set ? (4'b0001 << grant_id) : 4'b0000;
      if (state_nxt != state) begin
        timer <= 8'd0;
      end else if (timer != 8'hFF) begin
        timer <= timer + 8'd1;
      end
      if (grant) begin
        data       <= req_data[{winner, 3'b000} +: 8];
        grant_id   <= winner;
        last_grant <= winner;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized run against a
// cycle-level round-robin/transmitter reference model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        tx_busy;
  logic [3:0]  ack;
  logic        enable_txd;
  logic [7:0]  data;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic        idle;

  logic [3:0]  req_g;
  logic [31:0] req_data_g;
  logic        tx_busy_g;
  logic [3:0]  ack_g;
  logic        enable_g;
  logic [7:0]  data_g;
  logic [1:0]  grant_id_g;
  logic        timeout_g;
  logic        idle_g;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter u_dut (
    .sys_clk(clk), .sys_rst(sys_rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_busy(tx_busy), .enable_txd(enable_txd), .data(data), .grant_id(grant_id),
    .timeout_err(timeout_err), .idle(idle)
  );

  uart_tx_arbiter #(.START_TIMEOUT(8), .GAP_CYCLES(5)) u_gap (
    .sys_clk(clk), .sys_rst(sys_rst), .req(req_g), .req_data(req_data_g), .ack(ack_g),
    .tx_busy(tx_busy_g), .enable_txd(enable_g), .data(data_g), .grant_id(grant_id_g),
    .timeout_err(timeout_g), .idle(idle_g)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic busy_during);
    sys_rst   = 1'b1;
    req       = 4'b0;
    req_g     = 4'b0;
    tx_busy   = busy_during;
    tx_busy_g = 1'b0;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic wait_enable(output int n);
    n = 0;
    while (enable_txd !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Transmitter stand-in: called in the enable_txd cycle, raises busy d cycles later for len cycles.
  task automatic drive_frame(input int d, input int len, input bit drop,
                             output logic [3:0] acks, output int nacks);
    acks  = 4'b0;
    nacks = 0;
    for (int t = 0; t <= d + len; t++) begin
      tx_busy = (t >= d && t < d + len);
      tick();
      if (ack !== 4'b0) begin
        nacks++;
        acks = acks | ack;
        if (drop) req = req & ~ack;
      end
    end
    tx_busy = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    checks++; if (enable_txd !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", enable_txd); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
  endtask

  task automatic test_single;
    logic [3:0] acks;
    int nacks;
    do_reset(1'b0);
    req_data       = $urandom;
    req_data[15:8] = 8'h41;
    req            = 4'b0010;
    tick();
    checks++; if (enable_txd !== 1'b1) begin errors++; $display("FAIL single_enable: got %b want 1", enable_txd); end
    checks++; if (data !== 8'h41) begin errors++; $display("FAIL single_data: got %h want 41", data); end
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_grant_id: got %0d want 1", grant_id); end
    drive_frame(3, 20, 1'b1, acks, nacks);
    checks++; if (nacks !== 1) begin errors++; $display("FAIL single_ack_count: got %0d want 1", nacks); end
    checks++; if (acks !== 4'b0010) begin errors++; $display("FAIL single_ack_value: got %b want 0010", acks); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", idle); end
    tick();
    checks++; if (enable_txd !== 1'b0) begin errors++; $display("FAIL single_no_regrant: got %b want 0", enable_txd); end
  endtask

  task automatic test_round_robin;
    logic [3:0] acks;
    int nacks;
    int n;
    int w;
    do_reset(1'b0);
    req_data = $urandom;
    req      = 4'hF;
    for (int k = 0; k < 5; k++) begin
      w = k % 4;
      wait_enable(n);
      checks++; if (n !== 1) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d want 1", k, n); end
      checks++; if (grant_id !== 2'(w)) begin errors++; $display("FAIL rr_grant_id[%0d]: got %0d want %0d", k, grant_id, w); end
      checks++; if (data !== req_data[8*w +: 8]) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", k, data, req_data[8*w +: 8]); end
      drive_frame(1, 4, 1'b0, acks, nacks);
      checks++; if (nacks !== 1) begin errors++; $display("FAIL rr_ack_count[%0d]: got %0d want 1", k, nacks); end
      checks++; if (acks !== 4'(1 << w)) begin errors++; $display("FAIL rr_ack_value[%0d]: got %b want %b", k, acks, 4'(1 << w)); end
    end
    req = 4'b0;
  endtask

  task automatic test_timeout;
    int t;
    int nack;
    int n;
    do_reset(1'b0);
    req_data = $urandom;
    req      = 4'b0001;
    tick();
    checks++; if (enable_txd !== 1'b1) begin errors++; $display("FAIL to_enable: got %b want 1", enable_txd); end
    t    = 0;
    nack = 0;
    while (timeout_err !== 1'b1 && t < 40) begin
      tick();
      t++;
      if (ack !== 4'b0) nack++;
    end
    checks++; if (t !== 16) begin errors++; $display("FAIL to_latency: got %0d want 16", t); end
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL to_ack_with_err: got %b want 0000", ack); end
    checks++; if (nack !== 0) begin errors++; $display("FAIL to_no_ack: got %0d want 0", nack); end
    wait_enable(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL to_retry_spacing: got %0d want 2", n); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL to_retry_grant: got %0d want 0", grant_id); end
    req = 4'b0;
  endtask

  task automatic test_gap;
    int nack;
    int n;
    do_reset(1'b0);
    req_data_g = $urandom;
    req_g      = 4'b0011;
    tick();
    checks++; if (enable_g !== 1'b1) begin errors++; $display("FAIL gap_first_enable: got %b want 1", enable_g); end
    checks++; if (grant_id_g !== 2'd0) begin errors++; $display("FAIL gap_first_grant: got %0d want 0", grant_id_g); end
    nack = 0;
    for (int t = 0; t <= 5; t++) begin
      tx_busy_g = (t >= 1 && t < 5);
      tick();
      if (ack_g !== 4'b0) begin
        nack++;
        req_g = req_g & ~ack_g;
      end
    end
    n = 1;
    while (enable_g !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++; if (nack !== 1) begin errors++; $display("FAIL gap_ack_count: got %0d want 1", nack); end
    checks++; if (n !== 7) begin errors++; $display("FAIL gap_spacing: got %0d want 7", n); end
    checks++; if (grant_id_g !== 2'd1) begin errors++; $display("FAIL gap_second_grant: got %0d want 1", grant_id_g); end
    checks++; if (data_g !== req_data_g[15:8]) begin errors++; $display("FAIL gap_second_data: got %h want %h", data_g, req_data_g[15:8]); end
    req_g = 4'b0;
  endtask

  task automatic test_busy_blocking;
    int en_seen;
    int idle_low;
    int n;
    do_reset(1'b1);
    req_data = $urandom;
    req      = 4'b0100;
    en_seen  = 0;
    idle_low = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (enable_txd !== 1'b0) en_seen++;
      if (idle !== 1'b1) idle_low++;
    end
    checks++; if (en_seen !== 0) begin errors++; $display("FAIL block_enable: got %0d want 0", en_seen); end
    checks++; if (idle_low !== 0) begin errors++; $display("FAIL block_idle: got %0d want 0", idle_low); end
    tx_busy = 1'b0;
    wait_enable(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL block_release: got %0d want 2", n); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL block_grant: got %0d want 2", grant_id); end
    req = 4'b0;
  endtask

  task automatic test_reset_midframe;
    int nack;
    int n;
    do_reset(1'b0);
    req_data = $urandom;
    req      = 4'b0011;
    tick();
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_first_grant: got %0d want 0", grant_id); end
    nack = 0;
    for (int t = 0; t < 5; t++) begin
      tx_busy = 1'b1;
      tick();
      if (ack !== 4'b0) begin
        nack++;
        if (ack[0]) req_data[7:0] = 8'h5A;
      end
    end
    checks++; if (nack !== 1) begin errors++; $display("FAIL mid_first_ack: got %0d want 1", nack); end
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    checks++; if (enable_txd !== 1'b0) begin errors++; $display("FAIL mid_enable: got %b want 0", enable_txd); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL mid_data: got %h want 00", data); end
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL mid_ack: got %b want 0000", ack); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_grant_id: got %0d want 0", grant_id); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL mid_timeout: got %b want 0", timeout_err); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b want 1", idle); end
    nack = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (ack !== 4'b0) nack++;
    end
    checks++; if (nack !== 0) begin errors++; $display("FAIL mid_no_ack: got %0d want 0", nack); end
    tx_busy = 1'b0;
    wait_enable(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL mid_release: got %0d want 2", n); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_next_grant: got %0d want 0", grant_id); end
    checks++; if (data !== 8'h5A) begin errors++; $display("FAIL mid_next_data: got %h want 5a", data); end
    req = 4'b0;
  endtask

  // Reference: pointer scan for the winner, a scheduled busy window per frame,
  // ack one cycle after busy is first seen past the start cycle, idle from fall+1.
  task automatic test_random;
    int ptr, gw, w, d, len;
    int busy_start, busy_end, ack_cyc;
    bit model_idle, pend;
    logic [3:0] req_now;
    logic [3:0] exp_ack;
    do_reset(1'b0);
    req_data   = $urandom;
    ptr        = 3;
    gw         = 0;
    model_idle = 1'b1;
    pend       = 1'b0;
    busy_start = -100;
    busy_end   = -100;
    ack_cyc    = -100;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_now = req;
      checks++; if (enable_txd !== pend) begin errors++; $display("FAIL rand_enable@%0d: got %b want %b", cyc, enable_txd, pend); end
      if (pend) begin
        w = -1;
        for (int k = 1; k <= 4; k++) if (w < 0 && req_now[(ptr + k) % 4]) w = (ptr + k) % 4;
        checks++; if (grant_id !== 2'(w)) begin errors++; $display("FAIL rand_grant@%0d: got %0d want %0d", cyc, grant_id, w); end
        checks++; if (data !== req_data[8*w +: 8]) begin errors++; $display("FAIL rand_data@%0d: got %h want %h", cyc, data, req_data[8*w +: 8]); end
        ptr        = w;
        gw         = w;
        model_idle = 1'b0;
        d          = $urandom_range(0, 3);
        len        = $urandom_range(2, 6);
        busy_start = cyc + d;
        busy_end   = cyc + d + len;
        ack_cyc    = cyc + ((d > 1) ? d : 1) + 1;
      end
      exp_ack = (cyc == ack_cyc) ? 4'(1 << gw) : 4'b0;
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rand_ack@%0d: got %b want %b", cyc, ack, exp_ack); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rand_timeout@%0d: got %b want 0", cyc, timeout_err); end
      if (cyc == busy_end + 1) model_idle = 1'b1;
      checks++; if (idle !== model_idle) begin errors++; $display("FAIL rand_idle@%0d: got %b want %b", cyc, idle, model_idle); end
      tx_busy = (cyc >= busy_start && cyc < busy_end);
      for (int i = 0; i < 4; i++) begin
        if (exp_ack[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else req_data[8*i +: 8] = 8'($urandom);
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req_data[8*i +: 8] = 8'($urandom);
          req[i]             = 1'b1;
        end
      end
      pend = model_idle && (req != 4'b0);
      tick();
    end
    req     = 4'b0;
    tx_busy = 1'b0;
  endtask

  initial begin
    sys_rst    = 1'b1;
    req        = 4'b0;
    req_data   = 32'h0;
    tx_busy    = 1'b0;
    req_g      = 4'b0;
    req_data_g = 32'h0;
    tx_busy_g  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_gap();
    test_busy_blocking();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART byte transmitter between four requesters using round-robin arbitration. It sits between client logic (periodic counters, status reporters, command responders) and the UART send block. It latches the winning byte and issues the single-cycle `enable_txd` start pulse. It tracks the transmitter's `tx_busy` through the frame, acknowledges the requester, and flags transmitters that never start.

## Interface
- `START_TIMEOUT`, default 16: cycles after `enable_txd` within which `tx_busy` must rise; range 2..255.
- `GAP_CYCLES`, default 0: idle guard cycles inserted after each frame (`tx_busy` fall) before the next grant; range 0..255.

- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `sys_rst`  in  1  synchronous reset, active-high.
- `req`  in  4  bit i high = requester i has a byte pending; level, held until `ack[i]`.
- `req_data`  in  32  byte of requester i on bits [8i+7:8i]; stable while `req[i]` is high.
- `ack`  out  4  one-cycle pulse on bit i = requester i's byte accepted by the transmitter.
- `tx_busy`  in  1  from the transmitter; high while a frame is being shifted out.
- `enable_txd`  out  1  one-cycle start pulse to the transmitter.
- `data`  out  8  byte to the transmitter; valid from the `enable_txd` cycle until the next grant.
- `grant_id`  out  2  index of the current or most recent owner.
- `timeout_err`  out  1  one-cycle pulse when `tx_busy` fails to rise within `START_TIMEOUT`.
- `idle`  out  1  high when FSM is in IDLE.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE:**
  - A grant requires `|req` and `tx_busy==0`.
  - Winner = first set bit scanning from `last_grant+1` mod 4, upward with wrap.
  - On grant: latch `data <= req_data[winner]`, `grant_id <= winner`, `last_grant <= winner`; go to START.
- **START:** `enable_txd` high for exactly this one cycle; clear timer; go to WAIT_BUSY.
- **WAIT_BUSY:**
  - If `tx_busy==1`: pulse `ack[grant_id]` in the next cycle; go to WAIT_DONE.
  - Else if timer == `START_TIMEOUT-1`: pulse `timeout_err`, no ack, go to GAP. The requester keeps `req`; the pointer has already advanced, so other requesters are served first.
  - Else timer+1.
- **WAIT_DONE:** when `tx_busy==0`, go to GAP if `GAP_CYCLES>0`, else IDLE.
- **GAP:** count `GAP_CYCLES` cycles, then go to IDLE.
- Round-robin pointer reset value: `last_grant=3`, so requester 0 has highest priority after reset.
- Timers: 8-bit unsigned, no wrap; compared against parameter minus 1.
- Requester protocol:
  - Drop `req[i]` the cycle after `ack[i]`, or present new `req_data` and keep it high.
  - A held request is re-arbitrated normally, with no back-to-back grant if others are pending.
- A `req[i]` withdrawn after grant does not abort the transfer; `ack[i]` still pulses.
- `ack` is one-hot or zero; `ack` and `timeout_err` are never high in the same cycle.

## Timing
- Reset values: `enable_txd=0`, `data=8'h00`, `ack=4'b0`, `grant_id=0`, `timeout_err=0`, `idle=1`, state IDLE, `last_grant=3`, timers 0.
- Sequence, with cycle N = IDLE sampling a valid `req`:
  - `enable_txd` and the new `data` are high/valid at cycle N+1.
  - `tx_busy` first sampled high at cycle M produces `ack` at M+1.
- Minimum grant-to-grant spacing is frame length + 3 + `GAP_CYCLES` cycles.
- If `tx_busy` falls at cycle K with `GAP_CYCLES=0`, IDLE is reached at K+1 and the next `enable_txd` occurs at K+2 at the earliest.
- If `tx_busy` is high in IDLE (foreign frame or post-reset in-flight frame), no grant is made until it is low.
- Reset asserted mid-frame:
  - All outputs return to reset values the cycle after.
  - No ack is produced for the interrupted byte.
  - The transmitter is not aborted; the IDLE rule blocks a new grant until `tx_busy` falls.
- `tx_busy` already high in START is ignored. Only WAIT_BUSY samples it, so a transmitter that asserts busy the same cycle as `enable_txd` is acked one cycle later.

## Test plan
- Single request: `req=4'b0010`, `req_data[15:8]=8'h41`, transmitter busy 3 cycles after start for 20 cycles. Required: `enable_txd` at N+1 with `data=8'h41`, `grant_id=1`, one `ack=4'b0010`, then `idle=1`.
- Round-robin: after reset, `req=4'b1111` held, with each requester re-asserting after its ack. Required: grant order 0,1,2,3,0; exactly one ack per frame.
- Timeout: `START_TIMEOUT=16`, `tx_busy` tied low, `req=4'b0001`. Required: `timeout_err` pulses 16 cycles after `enable_txd`, no ack, then a retry `enable_txd` after GAP/IDLE.
- Gap: `GAP_CYCLES=5`, two requesters pending. Required: second `enable_txd` exactly 7 cycles after `tx_busy` falls.
- Busy blocking: `tx_busy=1` from reset for 30 cycles with `req=4'b0100`. Required: no `enable_txd` until 2 cycles after `tx_busy` falls.
- Reset mid-frame: assert `sys_rst` one cycle during WAIT_DONE. Required: all outputs at reset values, no ack, next grant to requester 0 if pending.
